// File: rtl/cpld_ramcfg_sync.sv
// Clocked capture of CPC RAM-configuration OUTs (port A15=0, data[7:6]=11) into a 6-bit block register.
// Optional glitch filter enabled by defining RAMCFG_FILTER_EN; otherwise a single qualifying sample accepts.
module cpld_ramcfg_sync #(
  parameter int          FILT_CYCLES = 2,
  parameter logic [5:0]  RESET_BLOCK = 6'b000000
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       iorq_b,
  input  logic       m1_b,
  input  logic       wr_b,
  input  logic       adr15,
  input  logic [7:0] datain,
  output logic [5:0] ramblock_q,
  output logic       cfg_stb,
  output logic [7:0] cfg_count
);

  typedef enum logic [1:0] {S_IDLE, S_QUAL, S_HOLD} state_t;

  state_t     r_state, w_next;
  logic       r_iorq, r_m1, r_wr, r_a15;
  logic [7:0] r_data;
  logic [5:0] r_block;
  logic       r_stb;
  logic [7:0] r_count;
  logic       w_qual, w_accept;

`ifdef RAMCFG_FILTER_EN
  logic [2:0] r_fcnt, w_fcnt_nxt;
`endif

  // Single register stage on every bus pin; the FSM only ever looks at these.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_iorq <= 1'b1;
      r_m1   <= 1'b1;
      r_wr   <= 1'b1;
      r_a15  <= 1'b1;
      r_data <= 8'h00;
    end else begin
      r_iorq <= iorq_b;
      r_m1   <= m1_b;
      r_wr   <= wr_b;
      r_a15  <= adr15;
      r_data <= datain;
    end
  end

  assign w_qual = !r_iorq & r_m1 & !r_wr & !r_a15 & r_data[7] & r_data[6];

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
`ifdef RAMCFG_FILTER_EN
    w_fcnt_nxt = r_fcnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_qual) begin
`ifdef RAMCFG_FILTER_EN
          if (FILT_CYCLES == 1) begin
            w_accept = 1'b1;
            w_next   = S_HOLD;
          end else begin
            w_fcnt_nxt = 3'd1;
            w_next     = S_QUAL;
          end
`else
          w_accept = 1'b1;
          w_next   = S_HOLD;
`endif
        end
      end
      S_QUAL: begin
`ifdef RAMCFG_FILTER_EN
        if (!w_qual) begin
          w_fcnt_nxt = 3'd0;
          w_next     = S_IDLE;
        end else if (r_fcnt == 3'(FILT_CYCLES - 1)) begin
          w_accept   = 1'b1;
          w_fcnt_nxt = 3'd0;
          w_next     = S_HOLD;
        end else begin
          w_fcnt_nxt = r_fcnt + 3'd1;
        end
`else
        w_next = S_IDLE;
`endif
      end
      // Wait out the rest of the I/O cycle so a long OUT is accepted once.
      S_HOLD: begin
        if (r_iorq) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= S_IDLE;
      r_block <= RESET_BLOCK;
      r_stb   <= 1'b0;
      r_count <= 8'h00;
    end else begin
      r_state <= w_next;
      r_stb   <= w_accept;
      if (w_accept) begin
        r_block <= r_data[5:0];
        r_count <= r_count + 8'd1;
      end
    end
  end

`ifdef RAMCFG_FILTER_EN
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) r_fcnt <= 3'd0;
    else          r_fcnt <= w_fcnt_nxt;
  end
`endif

  assign ramblock_q = r_block;
  assign cfg_stb    = r_stb;
  assign cfg_count  = r_count;

endmodule

// File: tb/tb_cpld_ramcfg_sync.sv
// Scoreboard bench for cpld_ramcfg_sync: each accepted OUT pushes its expected block/count/edge,
// popped when cfg_stb is seen. Works with RAMCFG_FILTER_EN defined or not.
module tb_cpld_ramcfg_sync;

  localparam int FILT = 2;
`ifdef RAMCFG_FILTER_EN
  localparam int EF = FILT;
`else
  localparam int EF = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       iorq_b = 1'b1, m1_b = 1'b1, wr_b = 1'b1, adr15 = 1'b0;
  logic [7:0] datain = 8'h00;
  logic [5:0] ramblock_q;
  logic       cfg_stb;
  logic [7:0] cfg_count;

  cpld_ramcfg_sync #(.FILT_CYCLES(FILT), .RESET_BLOCK(6'b000000)) dut (
    .clk(clk), .reset_b(reset_b), .iorq_b(iorq_b), .m1_b(m1_b), .wr_b(wr_b),
    .adr15(adr15), .datain(datain), .ramblock_q(ramblock_q), .cfg_stb(cfg_stb),
    .cfg_count(cfg_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] blk;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         total = 0, bad = 0, cyc = 0, stb_seen = 0;
  logic [5:0] m_blk = 6'b0;
  logic [7:0] m_cnt = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe must match the oldest outstanding expected accept.
  always @(negedge clk) begin
    if (reset_b && cfg_stb) begin
      exp_t e;
      stb_seen++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL stb_unexpected: cfg_stb=1 at edge %0d, required no strobe", cyc);
      end else begin
        e = q.pop_front();
        total++;
        if (ramblock_q !== e.blk) begin
          bad++;
          $display("FAIL stb_block: got %b, required %b", ramblock_q, e.blk);
        end
        total++;
        if (cfg_count !== e.cnt) begin
          bad++;
          $display("FAIL stb_count: got %0d, required %0d", cfg_count, e.cnt);
        end
        total++;
        if (cyc !== e.cyc) begin
          bad++;
          $display("FAIL stb_latency: strobe at edge %0d, required edge %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic bus_cycle(input logic a15, input logic [7:0] d, input int len,
                           input logic m1, input logic wr, input int idle);
    bit q_ok;
    @(negedge clk);
    iorq_b = 1'b0; m1_b = m1; wr_b = wr; adr15 = a15; datain = d;
    q_ok = m1 && !wr && !a15 && d[7] && d[6];
    if (q_ok && len >= EF) begin
      exp_t e;
      m_cnt = m_cnt + 8'd1;
      m_blk = d[5:0];
      e.blk = m_blk; e.cnt = m_cnt; e.cyc = cyc + 1 + EF;
      q.push_back(e);
    end
    repeat (len) @(negedge clk);
    iorq_b = 1'b1; m1_b = 1'b1; wr_b = 1'b1; adr15 = 1'b0;
    repeat (idle - 1) @(negedge clk);
  endtask

  task automatic check_state(input string name);
    repeat (3) @(negedge clk);
    total++;
    if (ramblock_q !== m_blk) begin
      bad++;
      $display("FAIL %s_block: got %b, required %b", name, ramblock_q, m_blk);
    end
    total++;
    if (cfg_count !== m_cnt) begin
      bad++;
      $display("FAIL %s_count: got %0d, required %0d", name, cfg_count, m_cnt);
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_stb: %0d accepts outstanding, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (ramblock_q !== 6'b0 || cfg_stb !== 1'b0 || cfg_count !== 8'h00) begin
      bad++;
      $display("FAIL reset_values: blk=%b stb=%b cnt=%0d, required 000000/0/0",
               ramblock_q, cfg_stb, cfg_count);
    end
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int s0 = stb_seen;
    bus_cycle(1'b0, 8'hC2, 3, 1'b1, 1'b0, 2);
    check_state("single");
    total++;
    if (stb_seen - s0 != 1) begin
      bad++;
      $display("FAIL single_stb_pulses: got %0d, required 1", stb_seen - s0);
    end
  endtask

  task automatic test_glitch();
    bus_cycle(1'b0, 8'hC5, 1, 1'b1, 1'b0, 3);
    check_state("glitch");
  endtask

  task automatic test_nonqual();
    int s0 = stb_seen;
    bus_cycle(1'b0, 8'h7F, 3, 1'b1, 1'b0, 2);
    bus_cycle(1'b1, 8'hC3, 3, 1'b1, 1'b0, 2);
    bus_cycle(1'b0, 8'hC3, 3, 1'b0, 1'b1, 2);
    check_state("nonqual");
    total++;
    if (stb_seen != s0) begin
      bad++;
      $display("FAIL nonqual_stb_pulses: got %0d, required 0", stb_seen - s0);
    end
  endtask

  task automatic test_back_to_back();
    int s0 = stb_seen;
    bus_cycle(1'b0, 8'hC7, 10, 1'b1, 1'b0, 1);
    bus_cycle(1'b0, 8'hFF, 3, 1'b1, 1'b0, 2);
    check_state("b2b");
    total++;
    if (stb_seen - s0 != 2) begin
      bad++;
      $display("FAIL b2b_stb_pulses: got %0d, required 2", stb_seen - s0);
    end
    total++;
    if (ramblock_q !== 6'b111111) begin
      bad++;
      $display("FAIL b2b_final_block: got %b, required 111111", ramblock_q);
    end
  endtask

  task automatic test_reset_mid_hold();
    exp_t e;
    @(negedge clk);
    iorq_b = 1'b0; m1_b = 1'b1; wr_b = 1'b0; adr15 = 1'b0; datain = 8'hC9;
    m_cnt = m_cnt + 8'd1;
    m_blk = 6'h09;
    e.blk = m_blk; e.cnt = m_cnt; e.cyc = cyc + 1 + EF;
    q.push_back(e);
    repeat (EF + 2) @(negedge clk);
    #2 reset_b = 1'b0;
    #1;
    total++;
    if (ramblock_q !== 6'b0 || cfg_stb !== 1'b0 || cfg_count !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_hold: blk=%b stb=%b cnt=%0d, required 000000/0/0",
               ramblock_q, cfg_stb, cfg_count);
    end
    @(negedge clk);
    iorq_b = 1'b1; wr_b = 1'b1;
    m_blk = 6'b0;
    m_cnt = 8'h00;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    check_state("post_reset");
  endtask

  task automatic test_wrap();
    int s0 = stb_seen;
    logic [7:0] d;
    for (int i = 0; i < 256; i++) begin
      d = {2'b11, 6'(i * 7)};
      bus_cycle(1'b0, d, 3, 1'b1, 1'b0, 1);
    end
    check_state("wrap");
    total++;
    if (cfg_count !== 8'h00) begin
      bad++;
      $display("FAIL wrap_count_zero: got %0d, required 0", cfg_count);
    end
    total++;
    if (stb_seen - s0 != 256) begin
      bad++;
      $display("FAIL wrap_stb_pulses: got %0d, required 256", stb_seen - s0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_nonqual();
    test_back_to_back();
    test_reset_mid_hold();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpld_ramcfg_sync.md
# cpld_ramcfg_sync

Synchronous bus front-end for the 512K RAM expansion CPLD. It watches Z80 I/O write cycles on the CPC expander bus, qualifies RAM-configuration writes (port address bit 15 low, data bits 7:6 = 11) with a clocked glitch filter, and holds the resulting 6-bit block register. Its outputs `ramblock_q` and `cfg_stb` feed the downstream bank-mapping decode that drives the external SRAM's high address and chip-select lines. It replaces an asynchronous edge-triggered latch with a clean, clocked capture.

## Interface

**Parameters**
- `FILT_CYCLES`, default 2: number of consecutive clock samples a qualified write must persist before it is accepted. Legal range 1..7.
- `RESET_BLOCK`, default 6'b000000: value loaded into `ramblock_q` on reset.

**Ports**
- `clk` input 1: CPC 4 MHz system clock; all state changes on its rising edge.
- `reset_b` input 1: asynchronous, active-low reset.
- `iorq_b` input 1: Z80 I/O request, active low.
- `m1_b` input 1: Z80 M1, active low. When asserted together with `iorq_b`, the cycle is an interrupt acknowledge and is never a write.
- `wr_b` input 1: Z80 write strobe, active low.
- `adr15` input 1: address bit 15.
- `datain` input 8: Z80 data bus.
- `ramblock_q` output 6: current configuration, {ccc bank, bbb scheme}.
- `cfg_stb` output 1: one-cycle pulse on the edge where `ramblock_q` is updated.
- `cfg_count` output 8: count of accepted configuration writes; wraps from 255 to 0.

## Operation

**Input stage**
- All bus inputs are registered once: `iorq_r`, `m1_r`, `wr_r`, `a15_r`, `data_r[7:0]`.
- Qualifier: `qual = !iorq_r & m1_r & !wr_r & !a15_r & data_r[7] & data_r[6]`.

**State machine** (3-bit filter counter `fcnt`)
- **IDLE**
  - If `qual` = 1 and `FILT_CYCLES` = 1: accept (see below), then go to HOLD.
  - If `qual` = 1 and `FILT_CYCLES` > 1: set `fcnt` = 1, go to QUAL.
  - Otherwise stay in IDLE.
- **QUAL**
  - If `qual` = 0: go to IDLE, clear `fcnt`, leave `ramblock_q` unchanged.
  - If `qual` = 1 and `fcnt` = `FILT_CYCLES`-1: accept, then go to HOLD.
  - Otherwise increment `fcnt`.
- **HOLD**
  - Stay while `iorq_r` = 0.
  - Go to IDLE on the first sample with `iorq_r` = 1.
  - One I/O cycle produces at most one acceptance, however long it lasts.

**Accept** (all on the same edge)
- `ramblock_q <= data_r[5:0]`
- `cfg_stb <= 1`
- `cfg_count <= cfg_count + 1` (mod 256)

**Other rules**
- `cfg_stb` is 0 in every cycle that is not an accept edge.
- Writes with `data_r[7:6]` ≠ 11, or with `adr15` high, are ignored. These are Gate Array and other ports.
- If data changes during QUAL while `qual` stays 1, the value captured is `data_r` on the accept edge.

## Timing

**Reset values** (asynchronous, while `reset_b` = 0)
- State = IDLE, `fcnt` = 0
- `ramblock_q` = `RESET_BLOCK`, `cfg_stb` = 0, `cfg_count` = 0
- All input registers: `iorq_r`, `m1_r`, `wr_r` = 1; `a15_r` = 1; `data_r` = 0

**Latency**
- Pins first sampled qualifying at edge 0 → `ramblock_q` and `cfg_stb` update at edge `FILT_CYCLES`.
- This requires `FILT_CYCLES` consecutive qualifying pin samples (edges 0..`FILT_CYCLES`-1).

**Boundary conditions**
- Reset asserted mid-QUAL or mid-HOLD: immediate return to reset values. A cycle still active when reset is released is seen as a new cycle.
- `qual` drops on the would-be accept sample: no accept.
- Back-to-back OUTs separated by at least one `iorq_r` = 1 sample: both are accepted.
- A Z80 OUT holds IORQ/WR low for roughly 3 clocks, so `FILT_CYCLES` up to 3 always accepts a genuine OUT.

## Configuration

- **`RAMCFG_FILTER_EN` defined:** the filter operates as described, using `FILT_CYCLES`.
- **Not defined:** `FILT_CYCLES` is forced to 1. Accept occurs at edge 1 after the first qualifying pin sample, and the QUAL state and `fcnt` are not synthesised. HOLD and all other behaviour are unchanged.

## Test plan

1. **Reset values:** assert `reset_b` = 0 mid-HOLD → `ramblock_q` = 0, `cfg_stb` = 0, `cfg_count` = 0 immediately, without a clock edge.
2. **Single OUT:** OUT &7FFF,&C2 held 3 clocks (`FILT_CYCLES` = 2) → `ramblock_q` = 6'b000010 at edge 2, a single `cfg_stb` pulse, `cfg_count` = 1.
3. **Glitch rejection:** IORQ/WR low for 1 clock with data &C5 (filter enabled, `FILT_CYCLES` = 2) → no strobe, `ramblock_q` unchanged. Same stimulus with the macro undefined → `ramblock_q` = 6'b000101.
4. **Non-qualifying cycles:**
   - Data &7F → ignored.
   - `adr15` = 1 with &C3 → ignored.
   - Interrupt acknowledge (`m1_b` = 0, `iorq_b` = 0, `wr_b` = 1) → ignored.
5. **Long cycle and back-to-back writes:** OUT &C7 with IORQ held 10 clocks → exactly one strobe. Then OUT &FF after one idle clock → second strobe, `ramblock_q` = 6'b111111, `cfg_count` = 2.
6. **Counter wrap:** 256 accepted writes → `cfg_count` returns to 0, with a `cfg_stb` pulse on every accept.
